// File: rtl/reg_axil_pkg.sv
// Shared types and constants for the register-port to AXI-Lite master bridge.
package reg_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Byte-address bits that must be zero for a 32-bit aligned access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/reg_to_axil_master.sv
// Single-outstanding register request port to AXI-Lite master bridge.
// Misaligned requests are answered locally with an error and never reach AXI.
module reg_to_axil_master
    import reg_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      reg_valid,
    input  logic                      reg_write,
    input  logic [ADDR_WIDTH-1:0]     reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_wdata,
    input  logic [DATA_WIDTH/8-1:0]   reg_wstrb,
    output logic                      reg_ready,
    output logic [DATA_WIDTH-1:0]     reg_rdata,
    output logic                      reg_error,

    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,   wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q,  bready_d;
    logic                    rready_q,  rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q,  w_done_d;
    logic                    ready_q,   ready_d;
    logic                    error_q,   error_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

    logic misaligned;
    assign misaligned = |(reg_addr[1:0] & ALIGN_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic; every AXI output is precomputed here and registered.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        error_d   = error_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (reg_valid) begin
                    addr_d  = reg_addr;
                    wdata_d = reg_wdata;
                    wstrb_d = reg_wstrb;
                    if (misaligned) begin
                        state_d = RSP;
                        error_d = 1'b1;
                        rdata_d = '0;
                    end else if (reg_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    error_d = resp_is_err(axi_bresp);
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axi_rvalid) begin
                    rdata_d = axi_rdata;
                    error_d = resp_is_err(axi_rresp);
                    state_d = RSP;
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bready_d = (state_d == WR_RESP);
        rready_d = (state_d == RD_RESP);
        ready_d  = (state_d == RSP);
    end

    assign reg_ready   = ready_q;
    assign reg_rdata   = rdata_q;
    assign reg_error   = error_q;
    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_araddr  = addr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

endmodule

// File: tb/tb_reg_to_axil_master.sv
// Randomized bench for reg_to_axil_master: a delay-configurable AXI-Lite slave
// plus a transaction-level model of result, latency and per-channel transfers.
module tb_reg_to_axil_master;

    logic        clk;
    logic        rst_n;
    logic        reg_valid;
    logic        reg_write;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ready;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    reg_to_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_ready(reg_ready),
        .reg_rdata(reg_rdata), .reg_error(reg_error),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          b_dly;
        int          r_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          n_aw;
        int          n_w;
        int          n_ar;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Slave configuration and observation state
    txn_t        cfg;
    bit          aw_got, w_got, ar_got, b_done, r_done, b_fire, r_fire;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int          n_aw, n_w, n_ar, n_b, n_r, viol;
    logic [31:0] got_awaddr, got_wdata, got_araddr;
    logic [3:0]  got_wstrb;
    bit          prev_aw, prev_w, prev_ar;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic slave_reset();
        axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
        axi_bvalid = 1'b0;  axi_bresp = 2'b00;
        axi_rvalid = 1'b0;  axi_rresp = 2'b00; axi_rdata = 32'h0;
        aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; viol = 0;
        got_awaddr = 32'h0; got_wdata = 32'h0; got_araddr = 32'h0; got_wstrb = 4'h0;
        prev_aw = 0; prev_w = 0; prev_ar = 0;
    endtask

    // Runs at each falling edge: decides what the slave presents at the next rising edge.
    task automatic slave_step();
        if (b_fire) begin axi_bvalid = 1'b0; b_fire = 0; end
        if (r_fire) begin axi_rvalid = 1'b0; r_fire = 0; end

        if (prev_aw && !axi_awvalid && !aw_got) viol++;
        if (prev_w  && !axi_wvalid  && !w_got)  viol++;
        if (prev_ar && !axi_arvalid && !ar_got) viol++;
        if (aw_got && axi_awvalid) viol++;
        if (w_got  && axi_wvalid)  viol++;
        if (ar_got && axi_arvalid) viol++;
        if (axi_bready && (!(aw_got && w_got) || b_done)) viol++;
        if (axi_rready && (!ar_got || r_done)) viol++;

        if (aw_got && w_got && !b_done) begin
            if (!axi_bvalid && b_wait >= cfg.b_dly) begin
                axi_bvalid = 1'b1;
                axi_bresp  = cfg.resp;
            end
            b_wait++;
        end
        if (axi_bvalid && axi_bready) begin n_b++; b_done = 1; b_fire = 1; end

        if (ar_got && !r_done) begin
            if (!axi_rvalid && r_wait >= cfg.r_dly) begin
                axi_rvalid = 1'b1;
                axi_rresp  = cfg.resp;
                axi_rdata  = cfg.rdata;
            end
            r_wait++;
        end
        if (axi_rvalid && axi_rready) begin n_r++; r_done = 1; r_fire = 1; end

        if (axi_awvalid && !aw_got) begin
            axi_awready = (aw_wait >= cfg.aw_dly);
            aw_wait++;
            if (axi_awready) begin n_aw++; aw_got = 1; got_awaddr = axi_awaddr; end
        end else axi_awready = 1'b0;

        if (axi_wvalid && !w_got) begin
            axi_wready = (w_wait >= cfg.w_dly);
            w_wait++;
            if (axi_wready) begin n_w++; w_got = 1; got_wdata = axi_wdata; got_wstrb = axi_wstrb; end
        end else axi_wready = 1'b0;

        if (axi_arvalid && !ar_got) begin
            axi_arready = (ar_wait >= cfg.ar_dly);
            ar_wait++;
            if (axi_arready) begin n_ar++; ar_got = 1; got_araddr = axi_araddr; end
        end else axi_arready = 1'b0;

        prev_aw = axi_awvalid; prev_w = axi_wvalid; prev_ar = axi_arvalid;
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reg_valid = 1'b0;
        #1;
        slave_reset();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Transaction-level expectation derived from the timing rules.
    function automatic exp_t model(input txn_t t, input bit b2b);
        exp_t e;
        e.n_aw = 0; e.n_w = 0; e.n_ar = 0; e.rdata = 32'h0;
        if (t.addr[1:0] != 2'b00) begin
            e.lat = 1;
            e.err = 1'b1;
        end else if (t.wr) begin
            e.lat  = 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
            e.err  = t.resp[1];
            e.n_aw = 1; e.n_w = 1;
        end else begin
            e.lat   = 3 + t.ar_dly + t.r_dly;
            e.err   = t.resp[1];
            e.rdata = t.rdata;
            e.n_ar  = 1;
        end
        e.lat += int'(b2b);
        return e;
    endfunction

    task automatic run_txn(input txn_t t, input bit b2b);
        exp_t e;
        int   lat;
        int   cap;
        if (!b2b) begin
            tick();
            chk("ready_pulse", 32'(reg_ready), 32'h0);
        end
        cfg = t;
        slave_reset();
        reg_valid = 1'b1;
        reg_write = t.wr;
        reg_addr  = t.addr;
        reg_wdata = t.wdata;
        reg_wstrb = t.strb;
        cap = b2b ? 2 : 1;
        lat = 0;
        while (lat < 200) begin
            tick();
            lat++;
            if (lat == cap) begin
                reg_write = 1'($urandom);
                reg_addr  = $urandom;
                reg_wdata = $urandom;
                reg_wstrb = 4'($urandom);
            end
            if (reg_ready) break;
        end
        reg_valid = 1'b0;
        if (!reg_ready) begin
            chk("timeout", 32'h1, 32'h0);
            do_reset();
            return;
        end
        e = model(t, b2b);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("error",   32'(reg_error), 32'(e.err));
        chk("rdata",   reg_rdata, e.rdata);
        chk("n_aw",    32'(n_aw), 32'(e.n_aw));
        chk("n_w",     32'(n_w),  32'(e.n_w));
        chk("n_ar",    32'(n_ar), 32'(e.n_ar));
        if (n_aw == 1) chk("awaddr", got_awaddr, t.addr);
        if (n_w == 1) begin
            chk("wdata", got_wdata, t.wdata);
            chk("wstrb", 32'(got_wstrb), 32'(t.strb));
        end
        if (n_ar == 1) chk("araddr", got_araddr, t.addr);
        chk("protocol", 32'(viol), 32'h0);
    endtask

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input int aw_d, input int w_d, input int ar_d,
                                input int b_d, input int r_d, input logic [1:0] resp,
                                input logic [31:0] rdata);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
        t.aw_dly = aw_d; t.w_dly = w_d; t.ar_dly = ar_d; t.b_dly = b_d; t.r_dly = r_d;
        t.resp = resp; t.rdata = rdata;
        return t;
    endfunction

    initial begin
        txn_t        t;
        logic [31:0] a;
        logic        seen;

        rst_n = 1'b0;
        reg_valid = 1'b0; reg_write = 1'b0; reg_addr = 32'h0; reg_wdata = 32'h0; reg_wstrb = 4'h0;
        cfg = mk(0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
        slave_reset();
        tick(); tick();
        chk("rst_ctrl", {26'h0, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, reg_ready}, 32'h0);
        chk("rst_err",    32'(reg_error), 32'h0);
        chk("rst_rdata",  reg_rdata, 32'h0);
        chk("rst_awaddr", axi_awaddr, 32'h0);
        chk("rst_wdata",  axi_wdata, 32'h0);
        rst_n = 1'b1;

        run_txn(mk(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0), 0);
        run_txn(mk(1, 32'h10, 32'hCAFEF00D, 4'h5, 2, 0, 0, 1, 0, 2'b00, 32'h0), 0);
        run_txn(mk(0, 32'h8, 32'h0, 4'h0, 0, 0, 3, 0, 5, 2'b00, 32'h12345678), 0);
        run_txn(mk(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hA5A5_0F0F), 0);
        run_txn(mk(1, 32'h24, 32'h01020304, 4'h3, 0, 1, 0, 2, 0, 2'b10, 32'h0), 0);
        run_txn(mk(1, 32'h6, 32'h55AA55AA, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0), 0);
        run_txn(mk(0, 32'h1, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF), 0);
        run_txn(mk(1, 32'h30, 32'h77777777, 4'h0, 1, 1, 0, 0, 0, 2'b01, 32'h0), 0);
        run_txn(mk(0, 32'h34, 32'h0, 4'h0, 0, 0, 1, 0, 0, 2'b00, 32'h87654321), 1);

        // Reset while AW/W are still outstanding.
        t = mk(1, 32'h40, 32'h11112222, 4'hF, 6, 6, 0, 0, 0, 2'b00, 32'h0);
        tick();
        cfg = t;
        slave_reset();
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = t.addr; reg_wdata = t.wdata; reg_wstrb = t.strb;
        tick(); tick();
        chk("pre_rst_awvalid", 32'(axi_awvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {26'h0, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, reg_ready}, 32'h0);
        reg_valid = 1'b0;
        slave_reset();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | reg_ready;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | reg_ready;
        end
        chk("rst_no_ready", 32'(seen), 32'h0);
        run_txn(mk(0, 32'h44, 32'h0, 4'h0, 0, 0, 2, 0, 1, 2'b00, 32'h0BADC0DE), 0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            else a[1:0] = 2'b00;
            t = mk(1'($urandom), a, $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom);
            run_txn(t, 1'($urandom_range(0, 1)));
        end

        tick();
        chk("final_ready", 32'(reg_ready), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_to_axil_master.md
# reg_to_axil_master

Bridge from the SoC's single-outstanding register request port to an AXI-Lite master port, one transaction at a time. Sits directly upstream of the peripheral AXI-Lite register slaves. It drives AW/W/B/R handshakes on their behalf and returns read data plus an error flag to the requester. It also rejects misaligned accesses locally, without touching AXI.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; only 32 is supported, and it sets the strobe width DATA_WIDTH/8
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- reg_valid  in  1  request valid; held until reg_ready
- reg_write  in  1  1 = write, 0 = read
- reg_addr  in  ADDR_WIDTH  byte address
- reg_wdata  in  DATA_WIDTH  write data
- reg_wstrb  in  DATA_WIDTH/8  byte strobes
- reg_ready  out  1  one-cycle completion pulse
- reg_rdata  out  DATA_WIDTH  read data, valid with reg_ready
- reg_error  out  1  error flag, valid with reg_ready
- axi_awaddr/axi_awvalid  out  ADDR_WIDTH/1;  axi_awready  in  1
- axi_wdata/axi_wstrb/axi_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1;  axi_wready  in  1
- axi_bresp  in  2;  axi_bvalid  in  1;  axi_bready  out  1
- axi_araddr/axi_arvalid  out  ADDR_WIDTH/1;  axi_arready  in  1
- axi_rdata  in  DATA_WIDTH;  axi_rresp  in  2;  axi_rvalid  in  1;  axi_rready  out  1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE**, reg_valid=1: capture addr, wdata, wstrb and write into holding registers. Request inputs are ignored afterwards.
  - addr[1:0]≠0 → RSP with error=1. No AXI activity.
  - otherwise write → WR_REQ, read → RD_REQ.
- **WR_REQ**: axi_awvalid and axi_wvalid both high, driven from the holding registers.
  - Flags aw_done/w_done track each handshake independently. Each valid drops the cycle after its own handshake.
  - Both done → WR_RESP. AW and W may complete in either order or in the same cycle.
- **WR_RESP**: axi_bready=1. On bvalid, latch error = bresp[1] (SLVERR/DECERR) → RSP.
- **RD_REQ**: axi_arvalid=1. On arready → RD_RESP.
- **RD_RESP**: axi_rready=1. On rvalid, latch rdata ← axi_rdata and error = rresp[1] → RSP.
- **RSP**: reg_ready=1 for exactly one cycle → IDLE.
  - reg_valid still high in the following IDLE cycle is taken as a new request.
- No valid is ever withdrawn before its handshake; there is no timeout.
- A write with wstrb=0 is still issued on AXI.
- Reset values: all AXI valids and readies 0, reg_ready 0, reg_error 0, reg_rdata 0, AXI address/data outputs 0, state IDLE.
- Reset mid-transaction: everything returns to reset values immediately. The in-flight request is never acknowledged.
- Error responses still carry data: reg_rdata takes axi_rdata even when rresp is an error. For writes, reg_rdata is 0.

## Timing
- Cycle 0 = IDLE with reg_valid=1.
- AXI valids rise at cycle 1. All AXI outputs come from registers; there is no combinational path from AXI inputs to AXI outputs.
- Minimum latency is 3 cycles, for both write and read. With same-cycle AW/W accept at cycle 1 and B at cycle 2, reg_ready is at cycle 3. Read: AR at cycle 1, R at cycle 2, reg_ready at cycle 3.
- Misaligned access: reg_ready at cycle 1.
- Back-to-back: the next request is accepted at the earliest one cycle after reg_ready. Throughput is at most one transaction per 4 cycles.
- A slave that raises awready/wready one cycle after valid (registered ready) must work. Each valid stays high until it samples its ready.
- bready/rready are high only in WR_RESP/RD_RESP. A B or R arriving in any other state is not accepted.

## Structure
- Package reg_axil_pkg holds:
  - the state enum;
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the alignment mask constant.
- Single module; no sub-module is warranted.

## Test plan
- Write 0x4 ← 0xDEADBEEF, strb 0xF. Slave accepts AW and W in the same cycle, bresp OKAY → one AW and one W handshake with those values, reg_ready at cycle 3, error=0.
- Write with W accepted 2 cycles before AW → wvalid drops after its handshake while awvalid holds. Exactly one transfer on each channel. Completes with error=0.
- Read 0x8, slave returns 0x12345678 with rresp OKAY after 5 wait cycles → arvalid held until arready. reg_rdata=0x12345678, error=0.
- Read with rresp=DECERR → reg_error=1 and reg_rdata=axi_rdata. A write with bresp=SLVERR → reg_error=1.
- Request at addr 0x6 → no AW/W/AR activity. reg_ready at cycle 1 with error=1.
- Assert rst_n=0 while in WR_REQ with awvalid high → all valids/readies drop at once and reg_ready never pulses. A read issued after release completes normally.
